// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory, with a bounded lock for bursts.
// Optional counters are enabled by defining DATA_MEMORY_ARBITER_STATS_EN.

module data_memory_arbiter_rsp (
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic        write,
  input  logic [31:0] mem_q,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata
);

  logic        vld_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) rdata_q <= write ? 32'h0 : mem_q;
    end
  end

  // Masked while reset is high so a response due in the reset cycle is dropped.
  assign rsp_valid = vld_q & ~reset;
  assign rsp_rdata = reset ? 32'h0 : rdata_q;

endmodule

module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic                  req0_write,
  input  logic [3:0]            req0_byteena,
  input  logic [31:0]           req0_wdata,
  input  logic                  req0_lock,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic                  req1_write,
  input  logic [3:0]            req1_byteena,
  input  logic [31:0]           req1_wdata,
  input  logic                  req1_lock,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_data,
  input  logic [31:0]           mem_q
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_grants0,
  output logic [31:0]           stat_grants1,
  output logic [31:0]           stat_conflicts
`endif
);

  localparam int NUM_PORTS = 2;
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] address;
    logic [3:0]            byteena;
    logic [31:0]           wdata;
  } req_t;

  req_t [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        grant;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [NUM_PORTS-1:0][31:0]  rsp_rdata;
  logic                        last_grant, last_grant_nxt;
  logic [3:0]                  hold_cnt, hold_cnt_nxt;
  logic                        sel;

  always_comb begin
    req[0] = '{valid: req0_valid, write: req0_write, lock: req0_lock,
               address: req0_address, byteena: req0_byteena, wdata: req0_wdata};
    req[1] = '{valid: req1_valid, write: req1_write, lock: req1_lock,
               address: req1_address, byteena: req1_byteena, wdata: req1_wdata};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  // Grant: lone requester wins; on a tie the locked owner keeps it until the hold budget runs out.
  always_comb begin
    grant = '0;
    if (!reset) begin
      case ({req[1].valid, req[0].valid})
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          if (req[last_grant].lock && (hold_cnt < HOLD_LIMIT))
            grant = last_grant ? 2'b10 : 2'b01;
          else
            grant = last_grant ? 2'b01 : 2'b10;
        end
        default: grant = '0;
      endcase
    end
  end

  // Next state
  always_comb begin
    last_grant_nxt = last_grant;
    hold_cnt_nxt   = hold_cnt;
    if (|grant) begin
      if (grant[last_grant]) begin
        hold_cnt_nxt = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
      end else begin
        last_grant_nxt = ~last_grant;
        hold_cnt_nxt   = '0;
      end
    end
  end

  // Outputs: idle cycles still steer the last owner's payload so the bus is deterministic.
  always_comb begin
    sel         = (|grant) ? grant[1] : last_grant;
    mem_address = req[sel].address;
    mem_data    = req[sel].wdata;
    mem_wren    = (|grant) & req[sel].write;
    mem_byteena = (|grant) ? req[sel].byteena : 4'b0000;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    data_memory_arbiter_rsp u_rsp (
      .clock     (clock),
      .reset     (reset),
      .accept    (grant[p]),
      .write     (req[p].write),
      .mem_q     (mem_q),
      .rsp_valid (rsp_valid[p]),
      .rsp_rdata (rsp_rdata[p])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp1_rdata = rsp_rdata[1];

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic [NUM_PORTS-1:0][31:0] grants_cnt;
  logic [31:0]                conflicts_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      grants_cnt    <= '0;
      conflicts_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (grant[p] && (grants_cnt[p] != 32'hFFFF_FFFF)) grants_cnt[p] <= grants_cnt[p] + 32'd1;
      if (req[0].valid && req[1].valid && (conflicts_cnt != 32'hFFFF_FFFF))
        conflicts_cnt <= conflicts_cnt + 32'd1;
    end
  end

  assign stat_grants0   = grants_cnt[0];
  assign stat_grants1   = grants_cnt[1];
  assign stat_conflicts = conflicts_cnt;
`endif

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-port round-robin arbiter sharing the single-port data memory between the core load/store unit (port 0) and the debug/loader port (port 1).
- Each requester uses a valid/ready request channel and a registered one-cycle response.
- At most one access reaches the memory per cycle.
- A bounded lock mechanism lets a requester issue back-to-back bursts without starving the other port.
- Sits between the core/debug fabric and the data memory's address/wren/byteena/data/q interface.

Parameters:
ADDR_WIDTH, 15, word-address width (matches the memory's DATA_BITS-2 address port)
MAX_HOLD, 4, max consecutive grants a locked port keeps while the other port is waiting; legal range 1..15

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  port 0 request present
req0_ready  output  1  port 0 request accepted this cycle
req0_address  input  ADDR_WIDTH  port 0 word address
req0_write  input  1  1 = write, 0 = read
req0_byteena  input  4  port 0 byte enables (writes only)
req0_wdata  input  32  port 0 write data
req0_lock  input  1  port 0 requests to keep the grant next cycle
rsp0_valid  output  1  port 0 response, one-cycle pulse
rsp0_rdata  output  32  port 0 read data
req1_*, rsp1_*  same set as port 0, for port 1
mem_address  output  ADDR_WIDTH  to memory address
mem_wren  output  1  to memory wren
mem_byteena  output  4  to memory byteena
mem_data  output  32  to memory data
mem_q  input  32  memory read data (combinational from mem_address)

Behaviour:
- State:
  - last_grant (1 bit), reset value 1, so port 0 wins the first tie.
  - hold_cnt (4 bits), reset value 0.
  - rsp registers.
- Grant is combinational each cycle:
  - Neither port valid: no grant.
  - Exactly one port valid: grant that port.
  - Both valid: grant last_grant if req[last_grant]_lock=1 and hold_cnt < MAX_HOLD-1. Otherwise grant !last_grant (round-robin).
- reqN_ready equals grantN. The ready may depend on valid. A transfer occurs when valid&&ready. The requester must hold valid and payload stable until ready.
- Granted cycle, memory side:
  - mem_address/byteena/data come from the granted port.
  - mem_wren = granted port's write bit.
  - A write commits at the next posedge.
- No-grant cycle, memory side:
  - mem_wren = 0.
  - mem_byteena = 0.
  - mem_address/data = port last_grant's inputs. This is don't-care for the memory but deterministic.
- Updates on grant:
  - Grant to the same port as last_grant: hold_cnt increments, saturating at 15.
  - Grant to the other port: last_grant flips and hold_cnt is cleared to 0.
  - No-grant cycle: last_grant and hold_cnt hold their values.
- Response, latency 1:
  - The cycle after an accepted request, rspN_valid=1 for exactly one cycle.
  - Read: rspN_rdata = mem_q sampled in the accept cycle, which is the pre-write memory contents.
  - Write: rspN_rdata = 0.
  - rspN_rdata holds its value when rspN_valid=0.
  - Back-to-back accepts give back-to-back responses. No backpressure exists on responses.
- A write with byteena=4'b0000 is still accepted and acknowledged. The memory contents are unchanged.
- Reset:
  - All rsp*_valid=0 and rsp*_rdata=0.
  - All ready outputs are 0 while reset=1.
  - mem_wren=0 while reset=1.
  - A request accepted in the cycle before reset asserts gets no response.
  - A write presented during reset is not performed.
- Single-port consequence: the ports are never granted in the same cycle. Invariant: grant0 & grant1 = 0.

Optional Feature:
Macro DATA_MEMORY_ARBITER_STATS_EN.
- When defined, adds three outputs, all cleared by reset and all saturating at 32'hFFFFFFFF:
  - stat_grants0 (32): accepted transfers on port 0.
  - stat_grants1 (32): accepted transfers on port 1.
  - stat_conflicts (32): cycles with both ports valid.
- When not defined, these ports and counters do not exist. Arbitration is identical in both builds.

Test Plan:
- Port 0 write addr 0x10, wdata 0xDEADBEEF, byteena 4'b1111; next cycle, port 0 read 0x10 -> write rsp0_valid pulse with rdata 0; read rsp0_rdata=0xDEADBEEF the cycle after the read accept.
- Both ports valid continuously, no locks, from reset -> grants alternate 0,1,0,1; each rspN_valid exactly one cycle after its grant.
- Both valid, port 1 lock=1 held, MAX_HOLD=4, port 1 granted first -> port 1 gets 4 consecutive grants, then port 0 gets 1, then port 1 again.
- Port 1 write byteena 4'b0101, wdata 0x11223344 to a word holding 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- Reset asserted the cycle after a port 0 read accept -> rsp0_valid stays 0; after reset, the first tie goes to port 0.
- With DATA_MEMORY_ARBITER_STATS_EN, 10 conflict cycles of alternating grants -> stat_conflicts=10, stat_grants0=5, stat_grants1=5.
